// File: rtl/sim_status_port.sv
// Memory-mapped end-of-test device: pass/fail status, cycle counter and a console byte FIFO.
// Optional watchdog timeout is enabled by defining SIM_STATUS_WATCHDOG_EN.
module sim_status_port #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WDOG_LIMIT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic        done,
    output logic        pass,
    output logic [30:0] code,
    output logic        timeout,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_TIMEOUT} state_t;

    state_t          state;
    logic [31:0]     cycle;
    logic [31:0]     overflow;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;

    logic [1:0]      offset;
    logic            wr_hit;
    logic            rd_hit;
    logic            status_wr;
    logic            push_req;
    logic            ovf_clr;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            expire;
    logic [CW-1:0]   cnt_n;
    logic [PW-1:0]   rd_ptr_n;
    logic [7:0]      head_n;
    logic [31:0]     rdata_c;

    // Address decode; the low two byte-address bits do not select anything.
    assign bus_hit   = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = bus_addr[3:2];
    assign wr_hit    = bus_we && bus_hit;
    assign rd_hit    = bus_re && bus_hit;
    assign status_wr = wr_hit && (offset == 2'd0) && bus_wdata[0];
    assign push_req  = wr_hit && (offset == 2'd1);
    assign ovf_clr   = wr_hit && (offset == 2'd3);

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus_addr[1:0];

    // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO.
    assign full     = (cnt == CW'(FIFO_DEPTH));
    assign pop      = con_valid && con_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;

    always_comb begin
        cnt_n = cnt;
        if (push && !pop) begin
            cnt_n = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_n = cnt - CW'(1);
        end
    end

    // Next head byte; bypasses the array when pushing into an empty FIFO.
    always_comb begin
        head_n = 8'h00;
        if (cnt_n != CW'(0)) begin
            if (push && (rd_ptr_n == wr_ptr)) begin
                head_n = bus_wdata[7:0];
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    // Read mux sees pre-write register values.
    always_comb begin
        rdata_c = 32'h0;
        case (offset)
            2'd0:    rdata_c = {code, done};
            2'd1:    rdata_c = {23'b0, full, 8'(cnt)};
            2'd2:    rdata_c = cycle;
            default: rdata_c = overflow;
        endcase
    end

`ifdef SIM_STATUS_WATCHDOG_EN
    logic [31:0] wdog;

    // Any hit write on the expiry cycle wins over the timeout.
    assign expire = (state == ST_RUN) && !wr_hit && (wdog == 32'(WDOG_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog <= 32'h0;
        end else if (wr_hit) begin
            wdog <= 32'h0;
        end else if (state == ST_RUN) begin
            wdog <= wdog + 32'd1;
        end
    end
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^32'(WDOG_LIMIT);
    assign expire = 1'b0;
`endif

    // Console storage is not reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            code      <= 31'h0;
            timeout   <= 1'b0;
            bus_rdata <= 32'h0;
            cycle     <= 32'h0;
            overflow  <= 32'h0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            con_valid <= 1'b0;
            con_data  <= 8'h00;
        end else begin
            cnt       <= cnt_n;
            rd_ptr    <= rd_ptr_n;
            con_valid <= (cnt_n != CW'(0));
            con_data  <= head_n;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            if (rd_hit) begin
                bus_rdata <= rdata_c;
            end

            if (drop) begin
                if (overflow != 32'hFFFF_FFFF) begin
                    overflow <= overflow + 32'd1;
                end
            end else if (ovf_clr) begin
                overflow <= 32'h0;
            end

            if (state == ST_RUN) begin
                cycle <= cycle + 32'd1;
            end

            case (state)
                ST_RUN: begin
                    if (status_wr) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        code  <= bus_wdata[31:1];
                        pass  <= (bus_wdata[31:1] == 31'h0);
                    end else if (expire) begin
                        state   <= ST_TIMEOUT;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                        code    <= 31'h7FFF_FFFF;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_status_port.sv
// Directed bench for sim_status_port: status, cycle counter, console FIFO, reset and watchdog.
module tb_sim_status_port;

    localparam logic [31:0] BASE     = 32'h0000_F000;
    localparam logic [31:0] A_STATUS = BASE + 32'h0;
    localparam logic [31:0] A_CON    = BASE + 32'h4;
    localparam logic [31:0] A_CYCLE  = BASE + 32'h8;
    localparam logic [31:0] A_OVF    = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic        done;
    logic        pass;
    logic [30:0] code;
    logic        timeout;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    sim_status_port #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(8),
        .WDOG_LIMIT(20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_hit  (bus_hit),
        .done     (done),
        .pass     (pass),
        .code     (code),
        .timeout  (timeout),
        .con_valid(con_valid),
        .con_data (con_data),
        .con_ready(con_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge; one rising edge performs the access.
    task automatic bus_op(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        bus_we    = we;
        bus_re    = re;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(negedge clk);
        bus_we = 1'b0;
        bus_re = 1'b0;
        rdata  = bus_rdata;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_op(1'b1, 1'b0, addr, wdata, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] rdata);
        bus_op(1'b0, 1'b1, addr, 32'h0, rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        con_ready = 1'b0;

        // Reset for two cycles, then three idle cycles before reading CYCLE.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_con_valid", 32'(con_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        idle(3);
        rd(A_CYCLE, rv);
        check("cycle_after_release", rv, 32'd3);

        bus_addr = BASE + 32'hC;
        #1 check("hit_top", 32'(bus_hit), 32'd1);
        bus_addr = BASE + 32'h10;
        #1 check("hit_above", 32'(bus_hit), 32'd0);
        bus_addr = BASE - 32'h4;
        #1 check("hit_below", 32'(bus_hit), 32'd0);
        @(negedge clk);
        wr(BASE + 32'h10, 32'h1);
        check("outside_write_done", 32'(done), 32'd0);
        rd(BASE + 32'h18, rv);
        check("outside_read_holds", rv, 32'd3);

        // Console FIFO: simultaneous read/write returns the pre-write count.
        bus_op(1'b1, 1'b1, A_CON, 32'h41, rv);
        check("rw_pre_value", rv, 32'd0);
        check("first_valid", 32'(con_valid), 32'd1);
        check("first_head", 32'(con_data), 32'h41);
        for (int i = 1; i < 10; i++) begin
            wr(A_CON, 32'h41 + 32'(i));
        end
        rd(A_CON, rv);
        check("con_full_count", rv, 32'h108);
        rd(A_OVF, rv);
        check("overflow_two", rv, 32'd2);

        con_ready = 1'b1;
        check("head_before_pop", 32'(con_data), 32'h41);
        wr(A_CON, 32'h4B);
        con_ready = 1'b0;
        rd(A_CON, rv);
        check("full_push_pop_count", rv, 32'h108);
        rd(A_OVF, rv);
        check("full_push_pop_ovf", rv, 32'd2);

        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(con_valid), 32'd1);
            check($sformatf("drain_byte_%0d", i), 32'(con_data),
                  (i == 7) ? 32'h4B : 32'h42 + 32'(i));
            @(negedge clk);
        end
        check("drained_empty", 32'(con_valid), 32'd0);
        con_ready = 1'b0;
        wr(A_OVF, 32'h1234);
        rd(A_OVF, rv);
        check("overflow_cleared", rv, 32'd0);

        // Pass result freezes the cycle counter.
        reset_pulse(2);
        wr(A_STATUS, 32'h1);
        check("pass_done", 32'(done), 32'd1);
        check("pass_pass", 32'(pass), 32'd1);
        check("pass_code", 32'(code), 32'd0);
        rd(A_CYCLE, rv);
        check("frozen_cycle_a", rv, 32'd1);
        rd(A_CYCLE, rv);
        check("frozen_cycle_b", rv, 32'd1);
        rd(A_STATUS, rv);
        check("pass_status_read", rv, 32'd1);

        // Pushes still accepted after done; then reset mid-test drops everything.
        wr(A_CON, 32'h5A);
        check("done_push_valid", 32'(con_valid), 32'd1);
        check("done_push_head", 32'(con_data), 32'h5A);
        wr(A_CON, 32'h59);
        wr(A_CON, 32'h58);
        rd(A_CON, rv);
        check("three_queued", rv, 32'd3);
        reset_pulse(1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        check("midrst_con_valid", 32'(con_valid), 32'd0);
        check("midrst_con_data", 32'(con_data), 32'd0);
        check("midrst_rdata", bus_rdata, 32'd0);
        rd(A_CYCLE, rv);
        check("midrst_cycle", rv, 32'd0);

        // Fail code, bit0=0 ignored, later STATUS writes ignored.
        wr(A_STATUS, 32'h4);
        check("bit0_clear_ignored", 32'(done), 32'd0);
        wr(A_STATUS, 32'hB);
        check("fail_done", 32'(done), 32'd1);
        check("fail_pass", 32'(pass), 32'd0);
        check("fail_code", 32'(code), 32'd5);
        wr(A_STATUS, 32'h1);
        check("sticky_code", 32'(code), 32'd5);
        check("sticky_pass", 32'(pass), 32'd0);
        rd(A_STATUS, rv);
        check("fail_status_read", rv, 32'hB);

`ifdef SIM_STATUS_WATCHDOG_EN
        reset_pulse(2);
        idle(19);
        check("wdog_before_limit", 32'(timeout), 32'd0);
        idle(1);
        check("wdog_timeout", 32'(timeout), 32'd1);
        check("wdog_done", 32'(done), 32'd1);
        check("wdog_pass", 32'(pass), 32'd0);
        check("wdog_code", 32'(code), 32'h7FFF_FFFF);
        wr(A_STATUS, 32'h1);
        check("wdog_sticky_pass", 32'(pass), 32'd0);

        reset_pulse(2);
        con_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(9);
            wr(A_CON, 32'h2E);
        end
        idle(9);
        check("kicked_no_timeout", 32'(timeout), 32'd0);
        check("kicked_not_done", 32'(done), 32'd0);
        con_ready = 1'b0;
`else
        reset_pulse(2);
        idle(30);
        check("no_wdog_timeout", 32'(timeout), 32'd0);
        check("no_wdog_done", 32'(done), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
